mux_sel_arbiter: RTL and testbench

//   Round-robin arbiter that generates the 2-bit select S for the 4:1 mux stage (channels A/B/C/D = 0/1/2/3).

---
 rtl/mux_sel_arbiter_if.sv | 29 ++
 rtl/mux_sel_arbiter.sv | 116 +++++++++++
 tb/tb_mux_sel_arbiter.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_sel_arbiter_if.sv
// mux_sel_arbiter_if -- request/grant bundle between the requesters/consumer and the mux-select arbiter.
// Revision 1.0. Optional LOCK line present when MUX_SEL_LOCK_EN is defined.
`default_nettype none

interface mux_sel_arbiter_if #(
  parameter int CNT_W = 8
);
  logic [3:0]       req;
  logic             ack;
  logic [1:0]       s;
  logic             valid;
  logic [3:0]       grant;
  logic [CNT_W-1:0] cnt;
`ifdef MUX_SEL_LOCK_EN
  logic             lock;

  modport master (output req, output ack, output lock,
                  input s, input valid, input grant, input cnt);
  modport slave  (input req, input ack, input lock,
                  output s, output valid, output grant, output cnt);
`else
  modport master (output req, output ack,
                  input s, input valid, input grant, input cnt);
  modport slave  (input req, input ack,
                  output s, output valid, output grant, output cnt);
`endif
endinterface

`default_nettype wire

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter -- round-robin 4-channel arbiter producing the 4:1 mux select with a minimum dwell.
// Revision 1.0. Define MUX_SEL_LOCK_EN to add a LOCK input that blocks ACK release.
`default_nettype none

module mux_sel_arbiter #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_sel_arbiter_if.slave   bus
);

  localparam int               DWELL_EFF = (DWELL == 0) ? 1 : DWELL;
  localparam logic [CNT_W-1:0] DWELL_M1  = CNT_W'(DWELL_EFF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       s_q;
  logic             valid_q;
  logic [3:0]       grant_q;
  logic [CNT_W-1:0] cnt_q;

  // First set bit of r in circular order starting at base.
  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] base);
    logic [1:0] res;
    logic [1:0] idx;
    logic       found;
    res   = base;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = base + 2'(i);
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  logic [3:0] others;
  logic [1:0] idle_win;
  logic [1:0] next_win;
  logic       lock_blk;
  logic       ack_rel;
  logic       dropped;
  logic       release_now;

`ifdef MUX_SEL_LOCK_EN
  assign lock_blk = bus.lock;
`else
  assign lock_blk = 1'b0;
`endif

  assign others      = bus.req & ~(4'b0001 << s_q);
  assign idle_win    = pick(bus.req, ptr);
  assign next_win    = pick(others, s_q + 2'd1);
  assign ack_rel     = bus.ack && !lock_blk && (cnt_q >= DWELL_M1);
  assign dropped     = !bus.req[s_q];
  assign release_now = ack_rel || dropped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      s_q     <= 2'd0;
      valid_q <= 1'b0;
      grant_q <= 4'b0000;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req) begin
            s_q     <= idle_win;
            valid_q <= 1'b1;
            grant_q <= 4'b0001 << idle_win;
            cnt_q   <= '0;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (release_now) begin
            ptr <= s_q + 2'd1;
            // Hand over on the same edge so the consumer sees no idle bubble.
            if (|others) begin
              s_q     <= next_win;
              grant_q <= 4'b0001 << next_win;
              cnt_q   <= '0;
            end else begin
              valid_q <= 1'b0;
              grant_q <= 4'b0000;
              state   <= IDLE;
            end
          end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s     = s_q;
  assign bus.valid = valid_q;
  assign bus.grant = grant_q;
  assign bus.cnt   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter -- directed self-checking bench for mux_sel_arbiter (DWELL=4, CNT_W=8).
// Revision 1.0.
`default_nettype none

module tb_mux_sel_arbiter;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  mux_sel_arbiter_if #(.CNT_W(8)) bus ();

  mux_sel_arbiter #(.DWELL(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    bus.ack = 1'b1;
    repeat (2) step();
    total++;
    if ({bus.s, bus.valid, bus.grant, bus.cnt} !== 15'd0) begin
      bad++;
      $display("FAIL reset_held: s=%0d valid=%b grant=%b cnt=%0d, want all 0", bus.s, bus.valid, bus.grant, bus.cnt);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      total++;
      if ({bus.s, bus.valid, bus.grant, bus.cnt} !== 15'd0) begin
        bad++;
        $display("FAIL reset_idle[%0d]: s=%0d valid=%b grant=%b cnt=%0d, want all 0", i, bus.s, bus.valid, bus.grant, bus.cnt);
      end
    end
    bus.ack = 1'b0;
  endtask

  task automatic test_single;
    bus.req = 4'b0100;
    step();
    total++;
    if (bus.s !== 2'd2 || bus.valid !== 1'b1 || bus.grant !== 4'b0100 || bus.cnt !== 8'd0) begin
      bad++;
      $display("FAIL single_grant: s=%0d valid=%b grant=%b cnt=%0d, want s=2 valid=1 grant=0100 cnt=0", bus.s, bus.valid, bus.grant, bus.cnt);
    end
    step();
    total++;
    if (bus.cnt !== 8'd1) begin
      bad++;
      $display("FAIL single_cnt1: cnt=%0d, want 1", bus.cnt);
    end
    bus.ack = 1'b1;
    step();
    total++;
    if (bus.valid !== 1'b1 || bus.s !== 2'd2 || bus.cnt !== 8'd2) begin
      bad++;
      $display("FAIL single_early_ack: valid=%b s=%0d cnt=%0d, want valid=1 s=2 cnt=2", bus.valid, bus.s, bus.cnt);
    end
    bus.ack = 1'b0;
    step();
    total++;
    if (bus.cnt !== 8'd3 || bus.valid !== 1'b1) begin
      bad++;
      $display("FAIL single_cnt3: cnt=%0d valid=%b, want cnt=3 valid=1", bus.cnt, bus.valid);
    end
    bus.ack = 1'b1;
    step();
    total++;
    if (bus.valid !== 1'b0 || bus.grant !== 4'b0000 || bus.s !== 2'd2) begin
      bad++;
      $display("FAIL single_release: valid=%b grant=%b s=%0d, want valid=0 grant=0000 s=2", bus.valid, bus.grant, bus.s);
    end
    // Pointer now 3: with channels 0 and 3 requesting, 3 must win.
    bus.ack = 1'b0;
    bus.req = 4'b1001;
    step();
    total++;
    if (bus.s !== 2'd3 || bus.grant !== 4'b1000) begin
      bad++;
      $display("FAIL single_ptr3: s=%0d grant=%b, want s=3 grant=1000", bus.s, bus.grant);
    end
    bus.req = 4'b0000;
    step();
    total++;
    if (bus.valid !== 1'b0) begin
      bad++;
      $display("FAIL single_drop_idle: valid=%b, want 0", bus.valid);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_s;
    bus.req = 4'b1111;
    bus.ack = 1'b1;
    step();
    for (int g = 0; g < 5; g++) begin
      for (int c = 0; c < 4; c++) begin
        exp_s = 2'(g % 4);
        total++;
        if (bus.s !== exp_s || bus.valid !== 1'b1 || bus.cnt !== 8'(c) || bus.grant !== (4'b0001 << exp_s)) begin
          bad++;
          $display("FAIL rr[%0d.%0d]: s=%0d valid=%b cnt=%0d grant=%b, want s=%0d valid=1 cnt=%0d", g, c, bus.s, bus.valid, bus.cnt, bus.grant, exp_s, c);
        end
        step();
      end
    end
    bus.req = 4'b0000;
    bus.ack = 1'b0;
    step();
    total++;
    if (bus.valid !== 1'b0) begin
      bad++;
      $display("FAIL rr_end: valid=%b, want 0", bus.valid);
    end
  endtask

  // Pointer is 2: channel 0 wins, then 1, then 0 again since 1 may not re-win while 0 waits.
  task automatic test_back_to_back;
    bus.req = 4'b0011;
    bus.ack = 1'b1;
    step();
    total++;
    if (bus.s !== 2'd0 || bus.valid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first: s=%0d valid=%b, want s=0 valid=1", bus.s, bus.valid);
    end
    repeat (4) step();
    total++;
    if (bus.s !== 2'd1 || bus.valid !== 1'b1 || bus.cnt !== 8'd0) begin
      bad++;
      $display("FAIL b2b_second: s=%0d valid=%b cnt=%0d, want s=1 valid=1 cnt=0", bus.s, bus.valid, bus.cnt);
    end
    repeat (4) step();
    total++;
    if (bus.s !== 2'd0 || bus.valid !== 1'b1 || bus.cnt !== 8'd0) begin
      bad++;
      $display("FAIL b2b_third: s=%0d valid=%b cnt=%0d, want s=0 valid=1 cnt=0", bus.s, bus.valid, bus.cnt);
    end
    bus.req = 4'b0000;
    bus.ack = 1'b0;
    step();
    total++;
    if (bus.valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end: valid=%b, want 0", bus.valid);
    end
  endtask

  task automatic test_drop;
    bus.req = 4'b0010;
    step();
    step();
    total++;
    if (bus.s !== 2'd1 || bus.cnt !== 8'd1) begin
      bad++;
      $display("FAIL drop_hold: s=%0d cnt=%0d, want s=1 cnt=1", bus.s, bus.cnt);
    end
    bus.req = 4'b1000;
    step();
    total++;
    if (bus.s !== 2'd3 || bus.valid !== 1'b1 || bus.cnt !== 8'd0 || bus.grant !== 4'b1000) begin
      bad++;
      $display("FAIL drop_handover: s=%0d valid=%b cnt=%0d grant=%b, want s=3 valid=1 cnt=0 grant=1000", bus.s, bus.valid, bus.cnt, bus.grant);
    end
  endtask

  task automatic test_async_reset;
    step();
    total++;
    if (bus.s !== 2'd3 || bus.valid !== 1'b1 || bus.cnt !== 8'd1) begin
      bad++;
      $display("FAIL areset_pre: s=%0d valid=%b cnt=%0d, want s=3 valid=1 cnt=1", bus.s, bus.valid, bus.cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.s, bus.valid, bus.grant, bus.cnt} !== 15'd0) begin
      bad++;
      $display("FAIL areset_now: s=%0d valid=%b grant=%b cnt=%0d, want all 0", bus.s, bus.valid, bus.grant, bus.cnt);
    end
    bus.req = 4'b0000;
    step();
    rst_n = 1'b1;
    step();
    total++;
    if (bus.valid !== 1'b0 || bus.s !== 2'd0) begin
      bad++;
      $display("FAIL areset_after: valid=%b s=%0d, want valid=0 s=0", bus.valid, bus.s);
    end
  endtask

  task automatic test_saturate;
    bus.req = 4'b0001;
    bus.ack = 1'b0;
    step();
    repeat (260) step();
    total++;
    if (bus.cnt !== 8'd255 || bus.valid !== 1'b1 || bus.s !== 2'd0) begin
      bad++;
      $display("FAIL saturate: cnt=%0d valid=%b s=%0d, want cnt=255 valid=1 s=0", bus.cnt, bus.valid, bus.s);
    end
    bus.ack = 1'b1;
    step();
    total++;
    if (bus.valid !== 1'b0) begin
      bad++;
      $display("FAIL saturate_release: valid=%b, want 0", bus.valid);
    end
    bus.req = 4'b0000;
    bus.ack = 1'b0;
    step();
  endtask

`ifdef MUX_SEL_LOCK_EN
  task automatic test_lock;
    bus.req  = 4'b0100;
    bus.lock = 1'b1;
    bus.ack  = 1'b1;
    step();
    repeat (10) step();
    total++;
    if (bus.s !== 2'd2 || bus.valid !== 1'b1 || bus.cnt !== 8'd10) begin
      bad++;
      $display("FAIL lock_hold: s=%0d valid=%b cnt=%0d, want s=2 valid=1 cnt=10", bus.s, bus.valid, bus.cnt);
    end
    bus.lock = 1'b0;
    step();
    total++;
    if (bus.valid !== 1'b0) begin
      bad++;
      $display("FAIL lock_release: valid=%b, want 0", bus.valid);
    end
    bus.req = 4'b0000;
    bus.ack = 1'b0;
    step();
  endtask
`endif

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    bus.ack = 1'b0;
`ifdef MUX_SEL_LOCK_EN
    bus.lock = 1'b0;
`endif
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_drop();
    test_async_reset();
    test_saturate();
`ifdef MUX_SEL_LOCK_EN
    test_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
